fifo_rd_packer: RTL and testbench

- Downstream consumer of the async FIFO read port, in the rd_clk domain.
- Pops 8-bit bytes from the FIFO and packs them little-endian into 32-bit words.
- Presents each word on a valid/ready stream to the next stage, with byte-keep and last flags for flushed partial words.
- Tracks FIFO read errors and counts words emitted.

---
 rtl/fifo_rd_pkg.sv | 26 ++
 rtl/fifo_rd_packer_if.sv | 31 +++
 rtl/rd_pack_outreg.sv | 38 +++
 rtl/fifo_rd_packer.sv | 112 +++++++++++
 tb/tb_fifo_rd_packer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side byte packer.
// Sized to match the async FIFO it drains.
package fifo_rd_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int BYTES = 4;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(BYTES + 1);

    typedef logic [WIDTH*BYTES-1:0] word_t;
    typedef logic [BYTES-1:0]       keep_t;
    typedef logic [CW-1:0]          cnt_t;

    localparam cnt_t FULL = cnt_t'(BYTES);

    function automatic keep_t keep_mask(input cnt_t n);
        keep_t m;
        m = '0;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus the packed-word valid/ready stream.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if;
    import fifo_rd_pkg::*;

    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             rd_ack;
    logic             rd_err;
    word_t            m_data;
    keep_t            m_keep;
    logic             m_last;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output rd_en,
        input  dout, empty, rd_ack, rd_err,
        output m_data, m_keep, m_last, m_valid,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        output dout, empty, rd_ack, rd_err,
        input  m_data, m_keep, m_last, m_valid,
        output m_ready
    );

endinterface

// File: rtl/rd_pack_outreg.sv
// Output word register: holds data stable until the consumer takes it.
// out_free tells the assembler a new word may be loaded this cycle.
module rd_pack_outreg
    import fifo_rd_pkg::*;
(
    input  logic  clk,
    input  logic  clear,
    input  logic  load,
    input  word_t ld_data,
    input  keep_t ld_keep,
    input  logic  ld_last,
    input  logic  ready,
    output logic  valid,
    output word_t data,
    output keep_t keep,
    output logic  last,
    output logic  out_free
);

    assign out_free = !valid || ready;

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            keep  <= ld_keep;
            last  <= ld_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian
// into words, with flush-driven partial words and error/word counters.
module fifo_rd_packer
    import fifo_rd_pkg::*;
(
    input  logic              rd_clk,
    input  logic              clear,
    input  logic              flush,
    fifo_rd_packer_if.master  bus,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    cnt_t        asm_cnt;
    cnt_t        base_cnt;
    word_t       asm_data;
    word_t       asm_nxt;
    logic        pend;
    logic        flush_pend;
    logic        out_free;
    logic        full_ld;
    logic        part_ld;
    logic        load;
    logic        ack_ok;
    logic        drained;
    logic        err_inc;
    logic [CW:0] need;
    keep_t       ld_keep;
    word_t       out_data;
    keep_t       out_keep;
    logic        out_last;
    logic        out_valid;

    assign ack_ok  = bus.rd_ack && pend;
    assign err_inc = bus.rd_err || (bus.rd_ack && !pend);
    assign drained = flush_pend && bus.empty && !pend;

    assign full_ld = out_free && (asm_cnt == FULL);
    assign part_ld = out_free && drained
                     && (asm_cnt != '0) && (asm_cnt != FULL);
    assign load    = full_ld || part_ld;

    // A word leaving assembly this cycle frees all lanes for the next pop.
    assign base_cnt  = load ? '0 : asm_cnt;
    assign need      = {1'b0, base_cnt} + {{CW{1'b0}}, pend};
    assign bus.rd_en = !clear && !bus.empty && (need < {1'b0, FULL});

    assign ld_keep = full_ld ? '1 : keep_mask(asm_cnt);

    // Lanes above asm_cnt stay zero, so partial words need no masking.
    always_comb begin
        asm_nxt = load ? '0 : asm_data;
        if (ack_ok) begin
            asm_nxt = asm_nxt
                      | (word_t'(bus.dout) << (WIDTH * int'(base_cnt)));
        end
    end

    always_ff @(posedge rd_clk) begin
        if (clear) begin
            pend       <= 1'b0;
            asm_cnt    <= '0;
            asm_data   <= '0;
            flush_pend <= 1'b0;
            word_cnt   <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            pend     <= bus.rd_en;
            asm_cnt  <= base_cnt + cnt_t'(ack_ok);
            asm_data <= asm_nxt;
            if (flush_pend) begin
                if (drained && ((asm_cnt == '0) || part_ld)) begin
                    flush_pend <= 1'b0;
                end
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (bus.m_valid && bus.m_ready) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (bus.rd_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

    rd_pack_outreg u_outreg (
        .clk      (rd_clk),
        .clear    (clear),
        .load     (load),
        .ld_data  (asm_data),
        .ld_keep  (ld_keep),
        .ld_last  (part_ld),
        .ready    (bus.m_ready),
        .valid    (out_valid),
        .data     (out_data),
        .keep     (out_keep),
        .last     (out_last),
        .out_free (out_free)
    );

    assign bus.m_data  = out_data;
    assign bus.m_keep  = out_keep;
    assign bus.m_last  = out_last;
    assign bus.m_valid = out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench: behavioural FIFO model feeding the packer, scoreboard
// of expected words checked whenever the stream transfers.
module tb_fifo_rd_packer;
    import fifo_rd_pkg::*;

    typedef struct packed {
        word_t data;
        keep_t keep;
        logic  last;
    } beat_t;

    logic             rd_clk;
    logic             clear;
    logic             flush;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;

    fifo_rd_packer_if bus ();

    fifo_rd_packer dut (
        .rd_clk     (rd_clk),
        .clear      (clear),
        .flush      (flush),
        .bus        (bus),
        .word_cnt   (word_cnt),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         pops       = 0;
    int         err_pop    = -1;
    logic [7:0] fifo_q[$];
    beat_t      sb[$];

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic exp_word(input word_t d, input keep_t k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        sb.push_back(b);
    endtask

    // FIFO read port: one-cycle answer, optional injected error pop.
    always @(posedge rd_clk) begin
        bus.rd_ack <= 1'b0;
        bus.rd_err <= 1'b0;
        if (bus.rd_en) begin
            if (fifo_q.size() == 0) begin
                bus.rd_err <= 1'b1;
            end else begin
                if (pops == err_pop) bus.rd_err <= 1'b1;
                else bus.rd_ack <= 1'b1;
                bus.dout <= fifo_q.pop_front();
                pops++;
            end
        end
        bus.empty <= (fifo_q.size() == 0);
    end

    always @(negedge rd_clk) begin
        beat_t got;
        beat_t exp;
        if (!clear && bus.m_valid && bus.m_ready) begin
            got.data = bus.m_data;
            got.keep = bus.m_keep;
            got.last = bus.m_last;
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(got), 64'h0);
            end else begin
                exp = sb.pop_front();
                check("word", 64'(got), 64'(exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int found;

        clear       = 1'b1;
        flush       = 1'b0;
        bus.m_ready = 1'b1;
        step();
        step();
        check("rst_rd_en",      64'(bus.rd_en),   64'h0);
        check("rst_m_valid",    64'(bus.m_valid), 64'h0);
        check("rst_m_data",     64'(bus.m_data),  64'h0);
        check("rst_m_keep",     64'(bus.m_keep),  64'h0);
        check("rst_m_last",     64'(bus.m_last),  64'h0);
        check("rst_word_cnt",   64'(word_cnt),    64'h0);
        check("rst_err_cnt",    64'(err_cnt),     64'h0);
        check("rst_err_sticky", 64'(err_sticky),  64'h0);
        clear = 1'b0;

        // Two full words streamed straight through.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i * 8'h11));
        exp_word(32'h44332211, 4'hF, 1'b0);
        exp_word(32'h88776655, 4'hF, 1'b0);
        repeat (20) step();
        check("t1_word_cnt", 64'(word_cnt),  64'd2);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Back-pressure: only two words' worth of bytes may be popped.
        bus.m_ready = 1'b0;
        p0 = pops;
        for (int i = 1; i <= 12; i++) fifo_q.push_back(8'(i));
        exp_word(32'h04030201, 4'hF, 1'b0);
        exp_word(32'h08070605, 4'hF, 1'b0);
        exp_word(32'h0C0B0A09, 4'hF, 1'b0);
        repeat (20) step();
        check("t2_pops",    64'(pops - p0),   64'd8);
        check("t2_rd_en",   64'(bus.rd_en),   64'h0);
        check("t2_valid",   64'(bus.m_valid), 64'h1);
        check("t2_hold_a",  64'(bus.m_data),  64'h04030201);
        repeat (3) step();
        check("t2_hold_b",  64'(bus.m_data),  64'h04030201);
        check("t2_keep",    64'(bus.m_keep),  64'hF);
        bus.m_ready = 1'b1;
        repeat (25) step();
        check("t2_word_cnt", 64'(word_cnt),  64'd5);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Partial word closed by flush once the FIFO drains.
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hB2);
        fifo_q.push_back(8'hC3);
        exp_word(32'h00C3B2A1, 4'h7, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (15) step();
        check("t3_word_cnt", 64'(word_cnt),  64'd6);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Flush with nothing assembled: no word, pending flag clears.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_flush_set",   64'(dut.flush_pend), 64'h1);
        step();
        check("t4_flush_clr",   64'(dut.flush_pend), 64'h0);
        repeat (3) step();
        check("t4_valid",       64'(bus.m_valid),    64'h0);
        check("t4_word_cnt",    64'(word_cnt),       64'd6);

        // Second pop answered with rd_err: that byte is skipped.
        err_pop = pops + 1;
        fifo_q.push_back(8'h10);
        fifo_q.push_back(8'h20);
        fifo_q.push_back(8'h30);
        fifo_q.push_back(8'h40);
        fifo_q.push_back(8'h50);
        exp_word(32'h50403010, 4'hF, 1'b0);
        repeat (15) step();
        check("t5_err_cnt",    64'(err_cnt),    64'd1);
        check("t5_err_sticky", 64'(err_sticky), 64'h1);
        check("t5_word_cnt",   64'(word_cnt),   64'd7);
        check("t5_sb_empty",   64'(sb.size()),  64'd0);

        // clear with two bytes assembled and the third ack arriving.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            step();
            if (dut.asm_cnt == 3'd2 && dut.pend) found = 1;
        end
        check("t6_setup", 64'(found), 64'd1);
        clear = 1'b1;
        #1;
        check("t6_rd_en_clr", 64'(bus.rd_en), 64'h0);
        step();
        clear = 1'b0;
        check("t6_valid",      64'(bus.m_valid), 64'h0);
        check("t6_data",       64'(bus.m_data),  64'h0);
        check("t6_keep",       64'(bus.m_keep),  64'h0);
        check("t6_last",       64'(bus.m_last),  64'h0);
        check("t6_word_cnt",   64'(word_cnt),    64'd0);
        check("t6_err_cnt",    64'(err_cnt),     64'd0);
        check("t6_err_sticky", 64'(err_sticky),  64'h0);
        check("t6_asm_cnt",    64'(dut.asm_cnt), 64'd0);
        exp_word(32'h07060504, 4'hF, 1'b0);
        exp_word(32'h00000008, 4'h1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        check("t6_word_cnt2",  64'(word_cnt),      64'd2);
        check("t6_fifo_empty", 64'(fifo_q.size()), 64'd0);
        check("t6_sb_empty",   64'(sb.size()),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
